mem_port_arbiter: RTL and testbench

- Shares the single 128-bit line-refill memory port between the instruction cache (read-only refills) and the data cache (line reads and write-backs).
- Latches the one-cycle request pulses from each cache and grants the port round-robin.
- Sequences one memory transaction at a time and returns the response to the granted cache as a one-cycle ready pulse.
- Sits between the cache pair and the memory/bus interface.

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one 128-bit line-refill memory port between the instruction cache
// (refill reads only) and the data cache (line reads and write-backs).
// Request pulses from each cache are latched into a pending flag plus the
// request fields. The port is granted round-robin, one memory transaction at
// a time, and the response goes back to the granted cache as a one-cycle
// ready pulse.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   ic_valid_req_i    I-cache refill request pulse, address on ic_addr_i
//   ic_ready_o        I-cache response pulse, line on ic_data_o
//   dc_valid_req_i    D-cache request pulse; dc_we_i=1 write-back, 0 read
//   dc_addr_i         D-cache address
//   dc_wdata_i        D-cache write-back line
//   dc_ready_o        D-cache response / write-done pulse, line on dc_data_o
//   mem_valid_req_o   memory request pulse (ISSUE cycle)
//   mem_we_o          memory write enable
//   mem_addr_o        line-aligned memory address
//   mem_wdata_o       memory write data
//   mem_ready_i       memory response / done
//   mem_data_i        memory read line
//   busy_o            high whenever the sequencer is not IDLE
//
// Handshake: every *_valid_req_* and *_ready_* signal is a single-cycle
// pulse with no back-pressure. A request pulse is accepted when its
// requester has nothing pending, or in the cycle its own response is being
// delivered (re-request wins over the clear); otherwise it is dropped.
// mem_ready_i is only honoured in WAIT.
//
// The FSM state is held in the `state` signal (type state_t) so checkers can
// bind to it directly; busy_o is its externally visible summary.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_valid_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ready_o,
  output logic [LINE_W-1:0] ic_data_o,
  input  logic              dc_valid_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ready_o,
  output logic [LINE_W-1:0] dc_data_o,
  output logic              mem_valid_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  // Clears the byte-within-line bits so the port always sees line addresses.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

  state_t state, state_nx;
  owner_t owner, owner_nx;
  owner_t last_grant;

  logic              ic_pend, dc_pend;
  logic [ADDR_W-1:0] ic_addr_q, dc_addr_q;
  logic              dc_we_q;
  logic [LINE_W-1:0] dc_wdata_q;
  logic [LINE_W-1:0] ic_data_q, dc_data_q;

  logic resp_ic, resp_dc;
  logic ic_accept, dc_accept;

  assign resp_ic = (state == S_RESP) && (owner == OWN_IC);
  assign resp_dc = (state == S_RESP) && (owner == OWN_DC);

  // A requester's latch is frozen while it is pending, so the owner's
  // fields stay stable for the whole transaction.
  assign ic_accept = ic_valid_req_i && (!ic_pend || resp_ic);
  assign dc_accept = dc_valid_req_i && (!dc_pend || resp_dc);

  // -------------------------------------------------------------------------
  // Request latches, response data registers, round-robin history
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ic_pend    <= 1'b0;
      dc_pend    <= 1'b0;
      ic_addr_q  <= '0;
      dc_addr_q  <= '0;
      dc_we_q    <= 1'b0;
      dc_wdata_q <= '0;
      ic_data_q  <= '0;
      dc_data_q  <= '0;
      last_grant <= OWN_IC;
    end else begin
      if (ic_accept) begin
        ic_pend   <= 1'b1;
        ic_addr_q <= ic_addr_i & LINE_MASK;
      end else if (resp_ic) begin
        ic_pend <= 1'b0;
      end

      if (dc_accept) begin
        dc_pend    <= 1'b1;
        dc_addr_q  <= dc_addr_i & LINE_MASK;
        dc_we_q    <= dc_we_i;
        dc_wdata_q <= dc_wdata_i;
      end else if (resp_dc) begin
        dc_pend <= 1'b0;
      end

      // A write-back's done response carries no line, so dc_data_o keeps
      // the last line read.
      if (state == S_WAIT && mem_ready_i) begin
        if (owner == OWN_IC) begin
          ic_data_q <= mem_data_i;
        end else if (!dc_we_q) begin
          dc_data_q <= mem_data_i;
        end
      end

      if (state == S_RESP) begin
        last_grant <= owner;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      owner <= OWN_IC;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    case (state)
      S_IDLE: begin
        if (ic_pend && dc_pend) begin
          // Tie: whoever was not served last goes first.
          owner_nx = (last_grant == OWN_IC) ? OWN_DC : OWN_IC;
          state_nx = S_ISSUE;
        end else if (dc_pend) begin
          owner_nx = OWN_DC;
          state_nx = S_ISSUE;
        end else if (ic_pend) begin
          owner_nx = OWN_IC;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (mem_ready_i) begin
          state_nx = S_RESP;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [LINE_W-1:0] sel_wdata;

  assign sel_addr  = (owner == OWN_DC) ? dc_addr_q : ic_addr_q;
  assign sel_we    = (owner == OWN_DC) && dc_we_q;
  assign sel_wdata = sel_we ? dc_wdata_q : '0;

  always_comb begin
    mem_valid_req_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    case (state)
      S_ISSUE: begin
        mem_valid_req_o = 1'b1;
        mem_we_o        = sel_we;
        mem_addr_o      = sel_addr;
        mem_wdata_o     = sel_wdata;
      end
      S_WAIT: begin
        mem_we_o    = sel_we;
        mem_addr_o  = sel_addr;
        mem_wdata_o = sel_wdata;
      end
      default: ;
    endcase
  end

  assign ic_ready_o = resp_ic;
  assign dc_ready_o = resp_dc;
  assign ic_data_o  = ic_data_q;
  assign dc_data_o  = dc_data_q;
  assign busy_o     = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Each test pushes the expected output
// events (memory requests and cache ready pulses) into exp_q; a monitor pops
// and compares whenever the DUT presents one. A small memory model answers
// every memory request after mem_delay cycles with a line derived from the
// address.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  // Event record: {kind[1:0], we, addr, data}
  localparam int W = 2 + 1 + ADDR_W + LINE_W;

  localparam logic [1:0] K_MEM = 2'd0;
  localparam logic [1:0] K_IC  = 2'd1;
  localparam logic [1:0] K_DC  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              ic_valid_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_ready_o;
  logic [LINE_W-1:0] ic_data_o;
  logic              dc_valid_req_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic              dc_ready_o;
  logic [LINE_W-1:0] dc_data_o;
  logic              mem_valid_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [LINE_W-1:0] mem_data_i;
  logic              busy_o;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ic_valid_req_i  (ic_valid_req_i),
    .ic_addr_i       (ic_addr_i),
    .ic_ready_o      (ic_ready_o),
    .ic_data_o       (ic_data_o),
    .dc_valid_req_i  (dc_valid_req_i),
    .dc_we_i         (dc_we_i),
    .dc_addr_i       (dc_addr_i),
    .dc_wdata_i      (dc_wdata_i),
    .dc_ready_o      (dc_ready_o),
    .dc_data_o       (dc_data_o),
    .mem_valid_req_o (mem_valid_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_ready_i     (mem_ready_i),
    .mem_data_i      (mem_data_i),
    .busy_o          (busy_o)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int last_mem_cyc = -1;
  int last_ic_cyc  = -1;
  int last_dc_cyc  = -1;
  int mem_delay    = 1;

  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, 24'h000000, 8'hA5};
  endfunction

  function automatic logic [W-1:0] ev(input logic [1:0] k, input logic we,
                                      input logic [ADDR_W-1:0] a,
                                      input logic [LINE_W-1:0] d);
    return {k, we, a, d};
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected act=%0h exp=none (cycle %0d)", name, act, cyc);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, e, cyc);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mem_valid_req_o) begin
      last_mem_cyc = cyc;
      sb_check("mem_req", ev(K_MEM, mem_we_o, mem_addr_o, mem_wdata_o));
    end
    if (ic_ready_o) begin
      last_ic_cyc = cyc;
      sb_check("ic_ready", ev(K_IC, 1'b0, '0, ic_data_o));
    end
    if (dc_ready_o) begin
      last_dc_cyc = cyc;
      sb_check("dc_ready", ev(K_DC, 1'b0, '0, dc_data_o));
    end
  end

  // ---------------- memory model ----------------
  initial begin
    logic [ADDR_W-1:0] a;
    mem_ready_i = 1'b0;
    mem_data_i  = '0;
    forever begin
      @(negedge clk);
      if (mem_valid_req_o) begin
        a = mem_addr_o;
        repeat (mem_delay) @(negedge clk);
        mem_ready_i = 1'b1;
        mem_data_i  = mem_line(a);
        @(negedge clk);
        mem_ready_i = 1'b0;
        mem_data_i  = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic ic_en, input logic [ADDR_W-1:0] ic_a,
                       input logic dc_en, input logic dc_we,
                       input logic [ADDR_W-1:0] dc_a,
                       input logic [LINE_W-1:0] dc_wd);
    ic_valid_req_i = ic_en;
    ic_addr_i      = ic_a;
    dc_valid_req_i = dc_en;
    dc_we_i        = dc_we;
    dc_addr_i      = dc_a;
    dc_wdata_i     = dc_wd;
    @(negedge clk);
    ic_valid_req_i = 1'b0;
    dc_valid_req_i = 1'b0;
    dc_we_i        = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s timeout act=%0d pending exp=0 pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int c0;
    int nb;
    int n;
    logic [LINE_W-1:0] wb_line;
    logic [ADDR_W-1:0] next_dc, next_ic;

    rst_n          = 1'b0;
    ic_valid_req_i = 1'b0;
    ic_addr_i      = '0;
    dc_valid_req_i = 1'b0;
    dc_we_i        = 1'b0;
    dc_addr_i      = '0;
    dc_wdata_i     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_readys", 128'({ic_ready_o, dc_ready_o, mem_valid_req_o, mem_we_o}), 128'd0);
    check("rst_mem_addr", 128'(mem_addr_o), 128'd0);
    check("rst_ic_data", ic_data_o, 128'd0);
    check("rst_dc_data", dc_data_o, 128'd0);

    // 1: single I-cache refill, memory answers one cycle after the request
    mem_delay = 1;
    exp_q.push_back(ev(K_MEM, 1'b0, 32'h0000_1230, '0));
    exp_q.push_back(ev(K_IC, 1'b0, '0, mem_line(32'h0000_1230)));
    c0 = cyc;
    pulse(1'b1, 32'h0000_1234, 1'b0, 1'b0, '0, '0);
    wait_done("t1", 30);
    check("t1_issue_lat", 128'(last_mem_cyc - c0), 128'd2);
    check("t1_ready_lat", 128'(last_ic_cyc - c0), 128'd4);
    @(negedge clk);

    // 2: simultaneous requests, D-cache goes first, one IDLE cycle between
    exp_q.push_back(ev(K_MEM, 1'b0, 32'h0000_2000, '0));
    exp_q.push_back(ev(K_DC, 1'b0, '0, mem_line(32'h0000_2000)));
    exp_q.push_back(ev(K_MEM, 1'b0, 32'h0000_3000, '0));
    exp_q.push_back(ev(K_IC, 1'b0, '0, mem_line(32'h0000_3000)));
    c0 = cyc;
    pulse(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_2000, '0);
    wait_done("t2", 40);
    check("t2_dc_ready_cyc", 128'(last_dc_cyc - c0), 128'd4);
    check("t2_ic_issue_cyc", 128'(last_mem_cyc - c0), 128'd6);
    check("t2_ic_ready_cyc", 128'(last_ic_cyc - c0), 128'd8);
    @(negedge clk);

    // 3: D-cache write-back; dc_data_o keeps the line read in test 2
    mem_delay = 2;
    wb_line = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_F0FF;
    exp_q.push_back(ev(K_MEM, 1'b1, 32'h0000_4000, wb_line));
    exp_q.push_back(ev(K_DC, 1'b0, '0, mem_line(32'h0000_2000)));
    pulse(1'b0, '0, 1'b1, 1'b1, 32'h0000_4008, wb_line);
    wait_done("t3", 30);
    check("t3_dc_data_kept", dc_data_o, mem_line(32'h0000_2000));
    @(negedge clk);

    // 4: slow memory; a second I-cache pulse during WAIT is ignored
    mem_delay = 10;
    exp_q.push_back(ev(K_MEM, 1'b0, 32'h0000_6000, '0));
    exp_q.push_back(ev(K_IC, 1'b0, '0, mem_line(32'h0000_6000)));
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      ic_valid_req_i = (i == 0) || (i == 5);
      ic_addr_i      = (i == 0) ? 32'h0000_6000 : 32'h0000_5000;
      if (busy_o) nb++;
      @(negedge clk);
    end
    ic_valid_req_i = 1'b0;
    check("t4_busy_cycles", 128'(nb), 128'd12);
    wait_done("t4", 30);
    check("t4_ic_data", ic_data_o, mem_line(32'h0000_6000));

    // 5: reset during WAIT, memory answers after reset
    exp_q.push_back(ev(K_MEM, 1'b0, 32'h0000_7000, '0));
    pulse(1'b1, 32'h0000_7000, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    check("t5_busy_before_rst", 128'(busy_o), 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t5_queue_empty", 128'(exp_q.size()), 128'd0);
    check("t5_busy", 128'(busy_o), 128'd0);
    check("t5_flags", 128'({ic_ready_o, dc_ready_o, mem_valid_req_o, mem_we_o}), 128'd0);
    check("t5_mem_addr", 128'(mem_addr_o), 128'd0);
    check("t5_mem_wdata", mem_wdata_o, 128'd0);
    check("t5_ic_data", ic_data_o, 128'd0);
    check("t5_dc_data", dc_data_o, 128'd0);

    // 6: both re-request in every RESP; grants alternate D,I,D,I,D,I
    mem_delay = 1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ev(K_MEM, 1'b0, 32'h0000_8000 + 32'(k * 256), '0));
      exp_q.push_back(ev(K_DC, 1'b0, '0, mem_line(32'h0000_8000 + 32'(k * 256))));
      exp_q.push_back(ev(K_MEM, 1'b0, 32'h0000_9000 + 32'(k * 256), '0));
      exp_q.push_back(ev(K_IC, 1'b0, '0, mem_line(32'h0000_9000 + 32'(k * 256))));
    end
    next_dc = 32'h0000_8100;
    next_ic = 32'h0000_9100;
    pulse(1'b1, 32'h0000_9000, 1'b1, 1'b0, 32'h0000_8000, '0);
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!(ic_ready_o || dc_ready_o) && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 50) begin
        failures++;
        $display("FAIL t6_resp_wait timeout act=no_ready exp=ready");
      end
      // The non-owner is still pending, so its junk address must be dropped.
      if (dc_ready_o) begin
        pulse(1'b1, 32'hDEAD_0000, 1'b1, 1'b0, next_dc, '0);
        next_dc = next_dc + 32'h100;
      end else begin
        pulse(1'b1, next_ic, 1'b1, 1'b0, 32'hDEAD_0000, '0);
        next_ic = next_ic + 32'h100;
      end
    end
    wait_done("t6", 80);
    repeat (5) @(negedge clk);
    check("t6_idle", 128'(busy_o), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
